kronos_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-ported memory bus between the Kronos core's instruction fetch port and its load/store port. It sits between `kronos_core` and the system memory. It registers the winning request onto the memory bus, holds it until `mem_ack`, and routes the acknowledge and read data back to the owner. Data accesses have priority, with a bounded-burst fairness counter so fetch is never starved.

---
 rtl/kronos_arb_pkg.sv | 17 +
 rtl/kronos_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_kronos_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kronos_arb_pkg.sv
// ---------------------------------------------------------------------------
// kronos_arb_pkg
// Shared types and constants for the Kronos memory arbiter.
//   arb_state_e : arbiter FSM state (IDLE, INSTR, DATA)
//   FETCH_MASK  : byte-enable mask driven onto the bus for instruction fetches
// ---------------------------------------------------------------------------
package kronos_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  localparam logic [3:0] FETCH_MASK = 4'hF;

endpackage

// File: rtl/kronos_mem_arbiter.sv
// ---------------------------------------------------------------------------
// kronos_mem_arbiter
// Shares one single-ported memory bus between the core's instruction fetch
// port and its load/store port. The winning request is registered onto the
// mem_* bus and held until mem_ack; the ack and read data are routed back to
// the owner. Data accesses win, but after DATA_BURST_MAX consecutive data
// grants with a fetch pending, the fetch is forced through.
//
// Ports:
//   clk, rstz              clock, asynchronous active-low reset
//   instr_addr/req         fetch request in;   instr_data/ack out
//   data_addr/wr_data/mask/wr_en/req  load/store request in
//   data_rd_data/ack       load/store response out
//   mem_addr/wr_data/mask/wr_en/req   registered shared-bus request out
//   mem_rd_data/ack        shared-bus response in (ack is a 1-cycle pulse)
// ---------------------------------------------------------------------------
module kronos_mem_arbiter
  import kronos_arb_pkg::*;
#(
  parameter int DATA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rstz,

  input  logic [31:0] instr_addr,
  output logic [31:0] instr_data,
  input  logic        instr_req,
  output logic        instr_ack,

  input  logic [31:0] data_addr,
  output logic [31:0] data_rd_data,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ack
);

  localparam int CNT_W = $clog2(DATA_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(DATA_BURST_MAX);

  arb_state_e       state_q,     state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [31:0]      addr_q,      addr_d;
  logic [31:0]      wr_data_q,   wr_data_d;
  logic [3:0]       mask_q,      mask_d;
  logic             wr_en_q,     wr_en_d;
  logic             req_q,       req_d;

  // Data wins unless a fetch is waiting and the data burst budget is spent.
  logic grant_data;
  assign grant_data = data_req && (!instr_req || (burst_cnt_q < BURST_MAX_C));

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      mask_q      <= '0;
      wr_en_q     <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      mask_q      <= mask_d;
      wr_en_q     <= wr_en_d;
      req_q       <= req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    mask_d      = mask_q;
    wr_en_d     = wr_en_q;
    req_d       = req_q;

    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d   = DATA;
          addr_d    = data_addr;
          wr_data_d = data_wr_data;
          mask_d    = data_mask;
          wr_en_d   = data_wr_en;
          req_d     = 1'b1;
          // Only consecutive data grants that actually held off a fetch count.
          if (instr_req) begin
            if (burst_cnt_q < BURST_MAX_C) begin
              burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
          end else begin
            burst_cnt_d = '0;
          end
        end else if (instr_req) begin
          state_d     = INSTR;
          addr_d      = instr_addr;
          wr_data_d   = '0;
          mask_d      = FETCH_MASK;
          wr_en_d     = 1'b0;
          req_d       = 1'b1;
          burst_cnt_d = '0;
        end
      end
      INSTR, DATA: begin
        // Request is not re-sampled here: a latched access always completes.
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wr_en_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        wr_en_d = 1'b0;
      end
    endcase
  end

  // An ack arriving in IDLE matches neither owner and is dropped.
  assign instr_ack    = mem_ack && (state_q == INSTR);
  assign data_ack     = mem_ack && (state_q == DATA);
  assign instr_data   = mem_rd_data;
  assign data_rd_data = mem_rd_data;

  assign mem_addr     = addr_q;
  assign mem_wr_data  = wr_data_q;
  assign mem_mask     = mask_q;
  assign mem_wr_en    = wr_en_q;
  assign mem_req      = req_q;

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_kronos_mem_arbiter
// Directed stimulus pushes expected bus transactions into a queue; a monitor
// compares the bus and the forwarded acks against the queue head every cycle.
// A small memory responder returns mem_ack after a programmable wait.
// ---------------------------------------------------------------------------
module tb_kronos_mem_arbiter;
  import kronos_arb_pkg::*;

  typedef struct {
    bit          is_instr;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  mask;
    logic        wr_en;
    logic [31:0] rd;
    int          cycles;
  } exp_t;

  logic        clk;
  logic        rstz;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        instr_req;
  logic        instr_ack;
  logic [31:0] data_addr;
  logic [31:0] data_rd_data;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic        data_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_mask;
  logic        mem_wr_en;
  logic        mem_req;
  logic [31:0] mem_rd_data;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  int   wait_cycles = 0;
  bit   resp_en = 1'b1;

  kronos_mem_arbiter #(.DATA_BURST_MAX(4)) dut (
    .clk          (clk),
    .rstz         (rstz),
    .instr_addr   (instr_addr),
    .instr_data   (instr_data),
    .instr_req    (instr_req),
    .instr_ack    (instr_ack),
    .data_addr    (data_addr),
    .data_rd_data (data_rd_data),
    .data_wr_data (data_wr_data),
    .data_mask    (data_mask),
    .data_wr_en   (data_wr_en),
    .data_req     (data_req),
    .data_ack     (data_ack),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_mask     (mem_mask),
    .mem_wr_en    (mem_wr_en),
    .mem_req      (mem_req),
    .mem_rd_data  (mem_rd_data),
    .mem_ack      (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit is_i, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] m, input logic we, input logic [31:0] rd,
                              input int cyc);
    exp_t e;
    e.is_instr = is_i;
    e.addr     = a;
    e.wr_data  = wd;
    e.mask     = m;
    e.wr_en    = we;
    e.rd       = rd;
    e.cycles   = cyc;
    return e;
  endfunction

  // Memory responder: ack after wait_cycles extra cycles of mem_req.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (resp_en) begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          wcnt = 0;
        end else if (mem_req) begin
          if (wcnt == wait_cycles) begin
            mem_ack = 1'b1;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
        end
      end
    end
  end

  // Monitor: compares bus contents and acks against the queue head.
  initial begin
    int   cyc;
    bit   post;
    exp_t e;
    cyc = 0;
    post = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstz) begin
        cyc = 0;
        post = 1'b0;
      end else begin
        if (post) begin
          chk("req_low_after_ack", {31'd0, mem_req}, 32'd0);
          chk("wr_en_low_after_ack", {31'd0, mem_wr_en}, 32'd0);
          post = 1'b0;
        end
        if (mem_req) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", {31'd0, mem_req}, 32'd0);
          end else begin
            e = exp_q[0];
            cyc++;
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_wr_data", mem_wr_data, e.wr_data);
            chk("mem_mask", {28'd0, mem_mask}, {28'd0, e.mask});
            chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, e.wr_en});
            if (mem_ack) begin
              $display("txn %s addr=0x%08h wr=%0d cycles=%0d", e.is_instr ? "I" : "D",
                       mem_addr, mem_wr_en, cyc);
              chk("instr_ack", {31'd0, instr_ack}, {31'd0, e.is_instr});
              chk("data_ack", {31'd0, data_ack}, {31'd0, !e.is_instr});
              if (e.is_instr) chk("instr_data", instr_data, e.rd);
              else            chk("data_rd_data", data_rd_data, e.rd);
              chk("txn_cycles", 32'(cyc), 32'(e.cycles));
              void'(exp_q.pop_front());
              cyc = 0;
              post = 1'b1;
            end else begin
              chk("no_early_ack", {30'd0, instr_ack, data_ack}, 32'd0);
            end
          end
        end else if (mem_ack) begin
          $display("stray mem_ack in IDLE");
          chk("stray_ack_dropped", {30'd0, instr_ack, data_ack}, 32'd0);
        end
      end
    end
  end

  // Wait (bounded) until at most n expected transactions remain, then step
  // 1 time unit past the edge so requesters can drop their requests.
  task automatic wait_q(input int n);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      if (exp_q.size() <= n) done = 1'b1;
    end
    #1;
    chk("wait_timeout", {31'd0, done}, 32'd1);
    if (!done) exp_q.delete();
  endtask

  task automatic stray_ack(input logic [31:0] rd);
    resp_en = 1'b0;
    @(posedge clk);
    #2;
    mem_rd_data = rd;
    mem_ack = 1'b1;
    @(posedge clk);
    #2;
    mem_ack = 1'b0;
    #1;
    chk("stray_state_idle", 32'(dut.state_q), 32'(IDLE));
    chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
    resp_en = 1'b1;
  endtask

  initial begin
    exp_t ei;
    exp_t ed;
    rstz = 1'b1;
    instr_addr = '0;
    instr_req = 1'b0;
    data_addr = '0;
    data_wr_data = '0;
    data_mask = '0;
    data_wr_en = 1'b0;
    data_req = 1'b0;
    mem_rd_data = '0;
    #2 rstz = 1'b0;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_mask", {28'd0, mem_mask}, 32'd0);
    chk("rst_acks", {30'd0, instr_ack, data_ack}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstz = 1'b1;
    @(posedge clk);
    #1;

    // Lone fetch, zero-wait memory.
    wait_cycles = 0;
    mem_rd_data = 32'h0000_0013;
    instr_addr = 32'h100;
    instr_req = 1'b1;
    exp_q.push_back(mk(1'b1, 32'h100, 32'h0, 4'hF, 1'b0, 32'h13, 1));
    wait_q(0);
    instr_req = 1'b0;
    @(posedge clk);
    #1;

    // Store with 2 wait cycles.
    wait_cycles = 2;
    mem_rd_data = 32'hCAFE_0001;
    data_addr = 32'h40;
    data_wr_data = 32'h0008_0AA8;
    data_mask = 4'h3;
    data_wr_en = 1'b1;
    data_req = 1'b1;
    exp_q.push_back(mk(1'b0, 32'h40, 32'h0008_0AA8, 4'h3, 1'b1, 32'hCAFE_0001, 3));
    wait_q(0);
    data_req = 1'b0;
    @(posedge clk);
    #1;

    // Contention: both held high, expect D,D,D,D,I,D,D,D,D,I,D,D.
    wait_cycles = 0;
    mem_rd_data = 32'h1234_5678;
    instr_addr = 32'h200;
    data_addr = 32'h80;
    data_wr_data = 32'h55;
    data_mask = 4'hF;
    data_wr_en = 1'b0;
    ei = mk(1'b1, 32'h200, 32'h0, 4'hF, 1'b0, 32'h1234_5678, 1);
    ed = mk(1'b0, 32'h80, 32'h55, 4'hF, 1'b0, 32'h1234_5678, 1);
    for (int i = 0; i < 12; i++) exp_q.push_back((i % 5 == 4) ? ei : ed);
    instr_req = 1'b1;
    data_req = 1'b1;
    wait_q(0);
    instr_req = 1'b0;
    data_req = 1'b0;
    chk("burst_after_contention", 32'(dut.burst_cnt_q), 32'd2);
    @(posedge clk);
    #1;

    // Priority without starvation: lone data grant clears the counter,
    // then a late fetch follows the data ack.
    wait_cycles = 2;
    mem_rd_data = 32'h0BAD_F00D;
    data_addr = 32'h300;
    data_wr_en = 1'b0;
    data_mask = 4'hF;
    data_req = 1'b1;
    exp_q.push_back(mk(1'b0, 32'h300, 32'h55, 4'hF, 1'b0, 32'h0BAD_F00D, 3));
    exp_q.push_back(mk(1'b1, 32'h400, 32'h0, 4'hF, 1'b0, 32'h0BAD_F00D, 3));
    @(posedge clk);
    #1;
    chk("burst_after_lone_data", 32'(dut.burst_cnt_q), 32'd0);
    instr_addr = 32'h400;
    instr_req = 1'b1;
    wait_q(1);
    data_req = 1'b0;
    wait_q(0);
    instr_req = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-access, then a late ack that must be dropped.
    wait_cycles = 5;
    data_addr = 32'h500;
    data_wr_data = 32'hA5A5_A5A5;
    data_mask = 4'h1;
    data_wr_en = 1'b1;
    data_req = 1'b1;
    exp_q.push_back(mk(1'b0, 32'h500, 32'hA5A5_A5A5, 4'h1, 1'b1, 32'h0, 6));
    repeat (2) @(posedge clk);
    #3;
    chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
    rstz = 1'b0;
    #1;
    chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_mem_wr_data", mem_wr_data, 32'd0);
    chk("arst_mem_mask", {28'd0, mem_mask}, 32'd0);
    chk("arst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("arst_state", 32'(dut.state_q), 32'(IDLE));
    chk("arst_acks", {30'd0, instr_ack, data_ack}, 32'd0);
    exp_q.delete();
    data_req = 1'b0;
    @(posedge clk);
    #1 rstz = 1'b1;
    stray_ack(32'hDEAD_0001);

    // Spurious ack in a plain IDLE period.
    @(posedge clk);
    stray_ack(32'hDEAD_0002);

    repeat (2) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

endmodule
